// File: rtl/csc_matrix_pipe_if.sv
// Stream and configuration bundle for the 3x3 colour-space converter.
// The master drives pixels and configuration; the slave is the converter.
interface csc_matrix_pipe_if #(
  parameter int DATA_WIDTH = 8,
  parameter int COEF_WIDTH = 12
);
  logic                  cfg_we;
  logic [3:0]            cfg_addr;
  logic [COEF_WIDTH-1:0] cfg_wdata;
  logic [1:0]            mode;

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_last;
  logic [DATA_WIDTH-1:0] in_c0;
  logic [DATA_WIDTH-1:0] in_c1;
  logic [DATA_WIDTH-1:0] in_c2;

  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic [DATA_WIDTH-1:0] out_c0;
  logic [DATA_WIDTH-1:0] out_c1;
  logic [DATA_WIDTH-1:0] out_c2;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, mode,
    output in_valid, in_last, in_c0, in_c1, in_c2,
    output out_ready,
    input  in_ready,
    input  out_valid, out_last, out_c0, out_c1, out_c2
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, mode,
    input  in_valid, in_last, in_c0, in_c1, in_c2,
    input  out_ready,
    output in_ready,
    output out_valid, out_last, out_c0, out_c1, out_c2
  );
endinterface

// File: rtl/csc_matrix_pipe.sv
// Four-stage 3x3 colour-space converter: multiply, partial sums, round/shift,
// saturate. Built-in BT.601/BT.709, programmable user matrix, and bypass.
module csc_matrix_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int COEF_WIDTH = 12,
  parameter int COEF_FRAC  = 10
) (
  input logic              clk,
  input logic              rst,
  csc_matrix_pipe_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int CW = COEF_WIDTH;
  localparam int OW = DATA_WIDTH + 1;
  localparam int PW = DATA_WIDTH + COEF_WIDTH + 1;
  localparam int AW = PW + 2;

  localparam logic signed [OW-1:0] OFF_MID = OW'(1 << (DW - 1));
  localparam logic signed [AW-1:0] RND     = AW'(1 << (COEF_FRAC - 1));
  localparam logic signed [AW-1:0] SAT_MAX = AW'((1 << DW) - 1);

  // Tables are held at 10 fractional bits and rescaled to COEF_FRAC.
  function automatic int builtin_coef(input logic is_709, input int idx);
    int v;
    int sh;
    case (idx)
      0:       v = is_709 ? 218  : 306;
      1:       v = is_709 ? 732  : 601;
      2:       v = is_709 ? 74   : 117;
      3:       v = is_709 ? -117 : -173;
      4:       v = is_709 ? -395 : -339;
      5:       v = 512;
      6:       v = 512;
      7:       v = is_709 ? -465 : -429;
      default: v = is_709 ? -47  : -83;
    endcase
    sh = COEF_FRAC - 10;
    if (sh >= 0) return v <<< sh;
    return (v + (1 <<< (-sh - 1))) >>> (-sh);
  endfunction

  function automatic logic [DW-1:0] saturate(input logic signed [AW-1:0] v);
    if (v < 0)       return '0;
    if (v > SAT_MAX) return '1;
    return v[DW-1:0];
  endfunction

  logic en;
  logic out_valid_q;

  assign en = !out_valid_q || bus.out_ready;

  // ---------------- user configuration registers ----------------
  logic signed [CW-1:0] k_q [9];
  logic signed [OW-1:0] o_q [3];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) k_q[i] <= CW'(builtin_coef(1'b0, i));
      o_q[0] <= '0;
      o_q[1] <= OFF_MID;
      o_q[2] <= OFF_MID;
    end else if (bus.cfg_we) begin
      case (bus.cfg_addr)
        4'd9:    o_q[0] <= bus.cfg_wdata[OW-1:0];
        4'd10:   o_q[1] <= bus.cfg_wdata[OW-1:0];
        4'd11:   o_q[2] <= bus.cfg_wdata[OW-1:0];
        default: if (bus.cfg_addr <= 4'd8) k_q[bus.cfg_addr] <= bus.cfg_wdata;
      endcase
    end
  end

  // ---------------- stage 1: coefficient select and products ----------------
  logic [DW-1:0]        in_c [3];
  logic signed [CW-1:0] coef_sel [9];
  logic signed [OW-1:0] s1_off_d [3];
  logic signed [PW-1:0] s1_prod_d [9];

  assign in_c[0] = bus.in_c0;
  assign in_c[1] = bus.in_c1;
  assign in_c[2] = bus.in_c2;

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      coef_sel[i] = k_q[i];
      if (bus.mode == 2'd0)      coef_sel[i] = CW'(builtin_coef(1'b0, i));
      else if (bus.mode == 2'd1) coef_sel[i] = CW'(builtin_coef(1'b1, i));
      s1_prod_d[i] = PW'($signed({1'b0, in_c[i % 3]})) * PW'(coef_sel[i]);
    end
    for (int r = 0; r < 3; r++) begin
      s1_off_d[r] = o_q[r];
      if (!bus.mode[1]) s1_off_d[r] = (r == 0) ? '0 : OFF_MID;
    end
  end

  logic                 s1_valid_q, s1_byp_q, s1_last_q;
  logic signed [PW-1:0] s1_prod_q [9];
  logic signed [OW-1:0] s1_off_q [3];
  logic [DW-1:0]        s1_raw_q [3];

  // ---------------- stage 2: row partial sums ----------------
  logic signed [AW-1:0] s2_pa_d [3];
  logic signed [AW-1:0] s2_pb_d [3];

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      s2_pa_d[r] = AW'(s1_prod_q[3*r]) + AW'(s1_prod_q[3*r+1]);
      s2_pb_d[r] = AW'(s1_prod_q[3*r+2]) + (AW'(s1_off_q[r]) <<< COEF_FRAC);
    end
  end

  logic                 s2_valid_q, s2_byp_q, s2_last_q;
  logic signed [AW-1:0] s2_pa_q [3];
  logic signed [AW-1:0] s2_pb_q [3];
  logic [DW-1:0]        s2_raw_q [3];

  // ---------------- stage 3: final sum, round-half-up, scale ----------------
  logic signed [AW-1:0] s3_res_d [3];

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      s3_res_d[r] = (s2_pa_q[r] + s2_pb_q[r] + RND) >>> COEF_FRAC;
    end
  end

  logic                 s3_valid_q, s3_byp_q, s3_last_q;
  logic signed [AW-1:0] s3_res_q [3];
  logic [DW-1:0]        s3_raw_q [3];

  // ---------------- stage 4: saturate or bypass ----------------
  logic [DW-1:0] out_c_d [3];

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      out_c_d[r] = s3_byp_q ? s3_raw_q[r] : saturate(s3_res_q[r]);
    end
  end

  logic          out_last_q;
  logic [DW-1:0] out_c_q [3];

  // Control and output registers: cleared by reset, frozen while blocked.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int r = 0; r < 3; r++) out_c_q[r] <= '0;
    end else if (en) begin
      s1_valid_q  <= bus.in_valid;
      s2_valid_q  <= s1_valid_q;
      s3_valid_q  <= s2_valid_q;
      out_valid_q <= s3_valid_q;
      if (s3_valid_q) begin
        out_last_q <= s3_last_q;
        out_c_q    <= out_c_d;
      end
    end
  end

  // Datapath registers need no reset; the valid chain qualifies them.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_prod_q <= s1_prod_d;
      s1_off_q  <= s1_off_d;
      s1_raw_q  <= in_c;
      s1_byp_q  <= (bus.mode == 2'd3);
      s1_last_q <= bus.in_last;

      s2_pa_q   <= s2_pa_d;
      s2_pb_q   <= s2_pb_d;
      s2_raw_q  <= s1_raw_q;
      s2_byp_q  <= s1_byp_q;
      s2_last_q <= s1_last_q;

      s3_res_q  <= s3_res_d;
      s3_raw_q  <= s2_raw_q;
      s3_byp_q  <= s2_byp_q;
      s3_last_q <= s2_last_q;
    end
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_c0    = out_c_q[0];
  assign bus.out_c1    = out_c_q[1];
  assign bus.out_c2    = out_c_q[2];

endmodule

// File: tb/tb_csc_matrix_pipe.sv
// Self-checking bench for csc_matrix_pipe: directed colour vectors plus a
// randomized stream scored against a plain-arithmetic reference model.
module tb_csc_matrix_pipe;
  localparam int DW = 8;
  localparam int CW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;

  csc_matrix_pipe_if #(.DATA_WIDTH(DW), .COEF_WIDTH(CW)) bus ();

  csc_matrix_pipe #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .COEF_FRAC(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] pix;
    logic        last;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t q[$];
  int   t601 [9] = '{306, 601, 117, -173, -339, 512, 512, -429, -83};
  int   t709 [9] = '{218, 732, 74, -117, -395, 512, 512, -465, -47};
  int   k_sh [9];
  int   o_sh [3];
  int   n_chk   = 0;
  int   n_pass  = 0;
  int   cyc     = 0;
  int   out_cnt = 0;
  bit   lat_chk = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic void reset_shadow();
    for (int i = 0; i < 9; i++) k_sh[i] = t601[i];
    o_sh[0] = 0;
    o_sh[1] = 128;
    o_sh[2] = 128;
  endfunction

  // Y/Cb/Cr = clamp(floor((sum(K*x) + O*1024 + 512) / 1024)), packed {c2,c1,c0}.
  function automatic logic [23:0] model(input int md, input int r, input int g, input int b);
    int k [9];
    int o [3];
    int x [3];
    int v;
    logic [23:0] res;
    x[0] = r; x[1] = g; x[2] = b;
    if (md == 3) return {b[7:0], g[7:0], r[7:0]};
    for (int i = 0; i < 9; i++) k[i] = (md == 0) ? t601[i] : (md == 1) ? t709[i] : k_sh[i];
    for (int i = 0; i < 3; i++) o[i] = (md == 2) ? o_sh[i] : ((i == 0) ? 0 : 128);
    res = '0;
    for (int row = 0; row < 3; row++) begin
      v = x[0]*k[3*row] + x[1]*k[3*row+1] + x[2]*k[3*row+2] + o[row]*1024;
      v = (v + 512) >>> 10;
      if (v < 0)   v = 0;
      if (v > 255) v = 255;
      res[row*8 +: 8] = v[7:0];
    end
    return res;
  endfunction

  // Scoreboard and protocol monitor, sampled on the falling edge.
  logic        prev_stall = 1'b0;
  logic [24:0] prev_out   = '0;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      q.delete();
      reset_shadow();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_data", {bus.out_last, bus.out_c2, bus.out_c1, bus.out_c0}, prev_out);
      end
      if (bus.out_valid && !bus.out_ready) chk("ready_in_stall", bus.in_ready, 0);
      if (bus.out_valid && bus.out_ready) begin
        chk("unexpected_out", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("pix", {bus.out_c2, bus.out_c1, bus.out_c0}, e.pix);
          chk("last", bus.out_last, e.last);
          if (e.lat) chk("latency", cyc - e.acc, 4);
          out_cnt++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e.pix  = model(int'(bus.mode), int'(bus.in_c0), int'(bus.in_c1), int'(bus.in_c2));
        e.last = bus.in_last;
        e.acc  = cyc;
        e.lat  = lat_chk;
        q.push_back(e);
      end
      if (bus.cfg_we) begin
        if (bus.cfg_addr <= 4'd8) k_sh[int'(bus.cfg_addr)] = int'($signed(bus.cfg_wdata));
        else if (bus.cfg_addr <= 4'd11) o_sh[int'(bus.cfg_addr) - 9] = int'($signed(bus.cfg_wdata[8:0]));
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = {bus.out_last, bus.out_c2, bus.out_c1, bus.out_c0};
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int r, input int g, input int b, input bit last);
    bit got = 1'b0;
    bus.in_c0    = 8'(r);
    bus.in_c1    = 8'(g);
    bus.in_c2    = 8'(b);
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!got) chk("accept_timeout", got, 1);
  endtask

  task automatic cfg_write(input int addr, input int data);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 4'(addr);
    bus.cfg_wdata = 12'(data);
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int c0, input int c1, input int c2);
    bit got = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        got = 1'b1;
        chk(tag, {bus.out_c2, bus.out_c1, bus.out_c0}, {8'(c2), 8'(c1), 8'(c0)});
        break;
      end
    end
    chk({tag, "_seen"}, got, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset_shadow();
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0; bus.mode = 2'd0;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    bus.in_c0 = '0; bus.in_c1 = '0; bus.in_c2 = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_out_data", {bus.out_c2, bus.out_c1, bus.out_c0}, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // BT.601 isolated vectors with latency check
    lat_chk = 1'b1;
    send(255, 255, 255, 1'b0); expect_out("601_white", 255, 128, 128);
    send(0, 0, 0, 1'b0);       expect_out("601_black", 0, 128, 128);
    send(255, 0, 0, 1'b1);     expect_out("601_red", 76, 85, 255);

    // back-to-back stream, mode switched mid-stream
    send(255, 0, 0, 1'b0);
    send(0, 255, 0, 1'b0);
    send(0, 0, 255, 1'b0);
    bus.mode = 2'd1;
    send(255, 255, 255, 1'b0);
    send(0, 255, 0, 1'b1);
    idle(8);
    send(0, 255, 0, 1'b0);     expect_out("709_green", 182, 30, 12);
    send(255, 255, 255, 1'b0); expect_out("709_white", 255, 128, 128);
    lat_chk = 1'b0;

    // backpressure burst: stall output for 3 cycles while pixel 2 is presented
    bus.mode = 2'd0;
    base = out_cnt;
    fork
      begin
        for (int i = 1; i <= 8; i++) send(i * 20, 255 - i * 10, i * 7, i == 8);
      end
      begin
        bit hit = 1'b0;
        for (int t = 0; t < 100; t++) begin
          @(posedge clk);
          #1;
          if (out_cnt == base + 1) begin
            hit = 1'b1;
            break;
          end
        end
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
        chk("bp_stall_applied", hit, 1);
      end
    join
    idle(10);
    chk("bp_count", out_cnt - base, 8);

    // user matrix: channel rotation, then negative Y offset
    for (int i = 0; i < 9; i++) cfg_write(i, (i == 1 || i == 5 || i == 6) ? 1024 : 0);
    for (int i = 9; i < 12; i++) cfg_write(i, 0);
    bus.mode = 2'd2;
    send(10, 20, 30, 1'b0); expect_out("user_rot", 20, 30, 10);
    cfg_write(9, -50);
    send(10, 20, 30, 1'b0); expect_out("user_off", 0, 30, 10);

    bus.mode = 2'd3;
    send(1, 2, 3, 1'b0); expect_out("bypass", 1, 2, 3);

    // reset with three pixels in flight
    bus.mode = 2'd0;
    send(50, 60, 70, 1'b0);
    send(80, 90, 100, 1'b0);
    send(110, 120, 130, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_flush", bus.out_valid, 0);
    @(posedge clk);
    #1;
    idle(8);
    bus.mode = 2'd2;
    send(255, 255, 255, 1'b0); expect_out("rst_user_white", 255, 128, 128);
    send(255, 0, 0, 1'b0);     expect_out("rst_user_red", 76, 85, 255);

    // randomized traffic with config writes, mode changes and backpressure
    for (int n = 0; n < 1500; n++) begin
      bus.out_ready = ($urandom_range(3) != 0);
      if ($urandom_range(15) == 0) bus.mode = 2'($urandom_range(3));
      bus.in_valid  = ($urandom_range(9) < 7);
      bus.in_c0     = 8'($urandom);
      bus.in_c1     = 8'($urandom);
      bus.in_c2     = 8'($urandom);
      bus.in_last   = ($urandom_range(7) == 0);
      bus.cfg_we    = ($urandom_range(9) == 0);
      bus.cfg_addr  = 4'($urandom);
      bus.cfg_wdata = 12'($urandom);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.out_ready = 1'b1;
    idle(12);
    chk("drain_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/csc_matrix_pipe.md
Name: csc_matrix_pipe

Overview:
- Parametrised 3x3 colour-space converter, successor to the fixed RGB-to-YCbCr stage in the video front end.
- Provides built-in BT.601 and BT.709 RGB-to-YCbCr matrices, a runtime-programmable user matrix with offsets, and a bypass mode.
- Applies rounding and saturation to the result.
- Uses a valid/ready stream handshake with full backpressure, and carries a last-of-line sideband through the pipeline.

Parameters:
- DATA_WIDTH, 8, unsigned width of each input and output channel.
- COEF_WIDTH, 12, signed coefficient width.
- COEF_FRAC, 10, fractional bits in each coefficient; built-in coefficient = round(c*2^COEF_FRAC).

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_we  input  1  user-register write strobe.
- cfg_addr  input  4  register select: 0-8 coefficient K[row*3+col]; 9-11 offset O[row]; 12-15 ignored.
- cfg_wdata  input  COEF_WIDTH  write data; offsets take the low DATA_WIDTH+1 bits, signed.
- mode  input  2  matrix select: 0 BT.601, 1 BT.709, 2 user, 3 bypass.
- in_valid  input  1  input pixel valid.
- in_ready  output  1  pipeline can accept a pixel.
- in_c0, in_c1, in_c2  input  DATA_WIDTH each  R, G, B.
- in_last  input  1  last pixel of line.
- out_valid  output  1  output pixel valid.
- out_ready  input  1  downstream accepts.
- out_c0, out_c1, out_c2  output  DATA_WIDTH each  Y, Cb, Cr (or R, G, B in bypass).
- out_last  output  1  delayed in_last.

Behaviour:
- Reset:
  - All stage valids clear; out_valid=0, out_data=0, out_last=0.
  - in_ready=1 from the first cycle after reset.
  - User registers load the BT.601 values.
  - Reset mid-stream discards every in-flight pixel, with no partial output.
- Handshake:
  - en = !out_valid || out_ready; in_ready = en.
  - A pixel is accepted when in_valid && in_ready.
  - When en=0, every stage holds and the outputs stay stable.
  - Pipeline bubbles do not stall upstream unless the output is blocked.
- Latency: 4 cycles from acceptance to out_valid when never stalled. Throughput is 1 pixel per cycle.
- Coefficient selection:
  - mode, K and O are sampled at acceptance and travel with the pixel through stage 1.
  - A cfg write or mode change affects only pixels accepted on later cycles.
  - A write and an acceptance in the same cycle: the pixel uses the old value.
- Built-in tables (COEF_FRAC=10), offsets {0, 2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)} for both:
  - BT.601: Y 306, 601, 117; Cb -173, -339, 512; Cr 512, -429, -83.
  - BT.709: Y 218, 732, 74; Cb -117, -395, 512; Cr 512, -465, -47.
- Pipeline stages:
  - S1 registers nine signed products, each DATA_WIDTH+COEF_WIDTH+1 bits, with the inputs zero-extended. It also registers O, the bypass flag, the raw inputs and last.
  - S2 computes row partial sums P_r*K0 + P_g*K1 and P_b*K2 + (O<<COEF_FRAC).
  - S3 adds the partial sums plus 2^(COEF_FRAC-1), then shifts arithmetic right by COEF_FRAC. The accumulator is product width + 2 bits and never overflows.
  - S4 saturates: a result <0 gives 0; a result >2^DATA_WIDTH-1 gives 2^DATA_WIDTH-1.
- Bypass: outputs equal the raw inputs at the same 4-cycle latency, and ordering with neighbouring pixels is preserved.
- out_last is asserted with exactly the pixel that carried in_last.

Test Plan:
- BT.601 colour vectors, mode=0, no stall:
  - (255,255,255) -> (255,128,128) exactly 4 cycles after acceptance.
  - (0,0,0) -> (0,128,128).
  - (255,0,0) -> Y=76, Cb=85, Cr=255 (saturated from 256).
- Back-to-back stream with mode 0 then 1 switched mid-stream:
  - Pixels before the switch use BT.601.
  - BT.709 (255,255,255) -> (255,128,128).
  - BT.709 (0,255,0) -> Y=182, Cb=30, Cr=12.
- Backpressure: 8-pixel burst with out_ready low for 3 cycles at pixel 2:
  - out_data and out_valid are held stable and in_ready=0 during the stall.
  - All 8 pixels emerge in order, with none lost or duplicated.
  - out_last appears only on pixel 8.
- User matrix:
  - Write K = {0,1024,0, 0,0,1024, 1024,0,0}, O=0, then set mode=2; (10,20,30) -> (20,30,10).
  - Write O[0]=-50, leaving K as above; (10,20,30) -> (0,30,10) (Y saturated low).
- Bypass: mode=3, (1,2,3) -> (1,2,3) after 4 cycles.
- Reset:
  - Pulse rst for 1 cycle with 3 pixels in flight: out_valid=0 next cycle and no stale pixel emerges.
  - After reset, mode=2 behaves as BT.601.
